// File: rtl/reg_cfg_master_if.sv
// Bus between reg_cfg_master and the REG block's zero-wait, pipelined AHB slave port.
// Latency: none; plain signal bundle.
// Backpressure: none; REG has no HREADY, so every address phase is followed by exactly one data phase.
//   AHB_HSEL/AHB_HWRITE/SET_STR/AHB_HADDR/AHB_HWDATA : master -> REG
//   AHB_HRDATA/CRYPT_INTR                            : REG -> master
interface reg_cfg_master_if;
  logic        AHB_HSEL;
  logic        AHB_HWRITE;
  logic        SET_STR;
  logic [19:0] AHB_HADDR;
  logic [31:0] AHB_HWDATA;
  logic [31:0] AHB_HRDATA;
  logic        CRYPT_INTR;

  modport master (
    output AHB_HSEL, AHB_HWRITE, SET_STR, AHB_HADDR, AHB_HWDATA,
    input  AHB_HRDATA, CRYPT_INTR
  );

  modport slave (
    input  AHB_HSEL, AHB_HWRITE, SET_STR, AHB_HADDR, AHB_HWDATA,
    output AHB_HRDATA, CRYPT_INTR
  );
endinterface

// File: rtl/reg_cfg_master.sv
// Programs the crypto REG block from a latched job descriptor, optionally reads it back, then enables the engine.
// Latency: first address phase 1 cycle after START; write-only job reaches the ENABLE data phase 12 cycles after START.
// Backpressure: none on the bus (zero-wait slave); START is ignored while BUSY=1.
//   Ports: AHB_HCLK/AHB_HRESET (sync, active-high); START/VERIFY_EN/KEY_IN/SAR_IN/DAR_IN/BSR_IN/CMD_IN job descriptor;
//   BUSY/DONE/ERR/ERR_ADDR job status; bus = master side of reg_cfg_master_if.
module reg_cfg_master #(
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter logic [15:0] TIMEOUT   = 16'd1024
) (
  input  logic             AHB_HCLK,
  input  logic             AHB_HRESET,
  input  logic             START,
  input  logic             VERIFY_EN,
  input  logic [191:0]     KEY_IN,
  input  logic [12:0]      SAR_IN,
  input  logic [12:0]      DAR_IN,
  input  logic [12:0]      BSR_IN,
  input  logic [1:0]       CMD_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [3:0]       ERR_ADDR,
  reg_cfg_master_if.master bus
);

  // S_RD_LAST is the data phase of the index-10 read with no new address phase:
  // ENABLE must not be issued until that last readback has been compared.
  // S_EN_DP is the data phase of the CTRL write.
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_RD_LAST, S_EN, S_EN_DP, S_WAIT, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;          // register index on the bus this cycle
  logic [15:0]    cnt_q, cnt_d;          // WAIT cycle counter
  logic [3:0]     err_addr_q, err_addr_d;
  logic [19:0]    haddr_q;
  logic [31:0]    hwdata_q;
  logic           rd_dp_q;               // a read data phase is in progress this cycle
  logic [3:0]     rd_idx_q;              // index whose read data is on HRDATA this cycle
  logic           latch_job;

  logic [191:0]   key_q;
  logic [12:0]    sar_q, dar_q, bsr_q;
  logic [1:0]     cmd_q;
  logic           verify_q;

  logic [31:0]    wr_word;
  logic [31:0]    exp_word;
  logic           rd_mismatch;
  logic           addr_phase_d;

  // Register image for index i, zero-extended to 32 bits.
  function automatic logic [31:0] reg_word(
    input logic [3:0]   i,
    input logic [191:0] key,
    input logic [12:0]  sar,
    input logic [12:0]  dar,
    input logic [12:0]  bsr,
    input logic [1:0]   cmd
  );
    logic [31:0] w;
    w = 32'h0;
    case (i)
      4'd0:    w = 32'h1;              // CTRL with ENABLE set
      4'd1:    w = key[31:0];
      4'd2:    w = key[63:32];
      4'd3:    w = key[95:64];
      4'd4:    w = key[127:96];
      4'd5:    w = key[159:128];
      4'd6:    w = key[191:160];
      4'd7:    w = {19'h0, sar};
      4'd8:    w = {19'h0, dar};
      4'd9:    w = {19'h0, bsr};
      4'd10:   w = {30'h0, cmd};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  assign wr_word     = reg_word(idx_q, key_q, sar_q, dar_q, bsr_q, cmd_q);
  assign exp_word    = reg_word(rd_idx_q, key_q, sar_q, dar_q, bsr_q, cmd_q);
  assign rd_mismatch = rd_dp_q && (bus.AHB_HRDATA != exp_word);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_addr_d = err_addr_q;
    latch_job  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d    = S_WR;
          idx_d      = 4'd1;
          err_addr_d = 4'h0;
          latch_job  = 1'b1;
        end
      end
      S_WR: begin
        if (idx_q == 4'd10) begin
          if (verify_q) begin
            state_d = S_RD;
            idx_d   = 4'd1;
          end else begin
            state_d = S_EN;
            idx_d   = 4'd0;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_RD: begin
        // A mismatch abandons the read already in flight; its data is never looked at.
        if (rd_mismatch) begin
          state_d    = S_ERR;
          err_addr_d = rd_idx_q;
        end else if (idx_q == 4'd10) begin
          state_d = S_RD_LAST;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_RD_LAST: begin
        if (rd_mismatch) begin
          state_d    = S_ERR;
          err_addr_d = rd_idx_q;
        end else begin
          state_d = S_EN;
          idx_d   = 4'd0;
        end
      end
      S_EN:    state_d = S_EN_DP;
      S_EN_DP: begin
        state_d = S_WAIT;
        cnt_d   = 16'd0;
      end
      S_WAIT: begin
        // Interrupt takes priority over a timeout landing on the same cycle.
        if (bus.CRYPT_INTR) begin
          state_d = S_IDLE;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          state_d    = S_ERR;
          err_addr_d = 4'hF;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign addr_phase_d = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_EN);

  always_ff @(posedge AHB_HCLK) begin
    if (AHB_HRESET) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      cnt_q      <= 16'd0;
      err_addr_q <= 4'h0;
      haddr_q    <= 20'h0;
      hwdata_q   <= 32'h0;
      rd_dp_q    <= 1'b0;
      rd_idx_q   <= 4'd0;
      key_q      <= '0;
      sar_q      <= 13'h0;
      dar_q      <= 13'h0;
      bsr_q      <= 13'h0;
      cmd_q      <= 2'b00;
      verify_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      err_addr_q <= err_addr_d;
      // HADDR only moves on a new address phase, so it holds while HSEL=0.
      if (addr_phase_d) begin
        haddr_q <= BASE_ADDR + {16'h0, idx_d};
      end
      // Write data trails its address phase by one cycle and then holds.
      if ((state_q == S_WR) || (state_q == S_EN)) begin
        hwdata_q <= wr_word;
      end
      rd_dp_q  <= (state_q == S_RD);
      rd_idx_q <= idx_q;
      if (latch_job) begin
        key_q    <= KEY_IN;
        sar_q    <= SAR_IN;
        dar_q    <= DAR_IN;
        bsr_q    <= BSR_IN;
        cmd_q    <= CMD_IN;
        verify_q <= VERIFY_EN;
      end
    end
  end

  assign bus.AHB_HSEL   = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_EN);
  assign bus.AHB_HWRITE = (state_q == S_WR) || (state_q == S_EN);
  assign bus.SET_STR    = bus.AHB_HSEL & bus.AHB_HWRITE;
  assign bus.AHB_HADDR  = haddr_q;
  assign bus.AHB_HWDATA = hwdata_q;

  // Pulses are suppressed in a cycle where reset is being sampled so an aborted job reports nothing.
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_WAIT) && bus.CRYPT_INTR && !AHB_HRESET;
  assign ERR      = (state_q == S_ERR) && !AHB_HRESET;
  assign ERR_ADDR = err_addr_q;

endmodule

// File: tb/tb_reg_cfg_master.sv
// Directed bench for reg_cfg_master with a behavioural REG slave model.
// Cycle numbering: cycle 0 is the cycle START is high; cycle k is k clocks later.
// Inputs change 1ns after posedge; outputs are checked 3ns after posedge.
module tb_reg_cfg_master;
  localparam logic [19:0] BASE = 20'hFFFF8;
  localparam logic [15:0] TMO  = 16'd16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         verify_en;
  logic [191:0] key;
  logic [12:0]  sar, dar, bsr;
  logic [1:0]   cmd;
  logic         busy, done, err;
  logic [3:0]   err_addr;

  reg_cfg_master_if bus();

  reg_cfg_master #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .AHB_HCLK   (clk),
    .AHB_HRESET (rst),
    .START      (start),
    .VERIFY_EN  (verify_en),
    .KEY_IN     (key),
    .SAR_IN     (sar),
    .DAR_IN     (dar),
    .BSR_IN     (bsr),
    .CMD_IN     (cmd),
    .BUSY       (busy),
    .DONE       (done),
    .ERR        (err),
    .ERR_ADDR   (err_addr),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected job, kept apart from the live inputs which get scrambled while BUSY.
  logic [191:0] ej_key;
  logic [12:0]  ej_sar, ej_dar, ej_bsr;
  logic [1:0]   ej_cmd;

  // REG slave model and event counters.
  logic [31:0] model [0:15];
  logic [3:0]  corrupt_idx = 4'hF;
  logic        wr_pend = 1'b0;
  logic [3:0]  wr_pidx = 4'd0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_val  = 32'h0;
  int n_done = 0, n_errp = 0, n_ctrl = 0, n_rd = 0;

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    bus.AHB_HRDATA = 32'h0;
    bus.CRYPT_INTR = 1'b0;
  end

  always @(negedge clk) begin
    logic [19:0] off;
    if (done) n_done = n_done + 1;
    if (err)  n_errp = n_errp + 1;
    if (wr_pend) begin
      model[wr_pidx] = bus.AHB_HWDATA;
      if (wr_pidx == 4'd0) n_ctrl = n_ctrl + 1;
    end
    off     = bus.AHB_HADDR - BASE;
    wr_pend = bus.AHB_HSEL && bus.AHB_HWRITE;
    wr_pidx = off[3:0];
    rd_pend = bus.AHB_HSEL && !bus.AHB_HWRITE;
    if (rd_pend) begin
      n_rd   = n_rd + 1;
      rd_val = (off[3:0] == corrupt_idx) ? 32'h11 : model[off[3:0]];
    end
  end

  // Read data appears in the data phase, i.e. the cycle after the address phase.
  always @(posedge clk) begin
    if (rd_pend) bus.AHB_HRDATA <= rd_val;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) next_cycle();
  endtask

  function automatic logic [31:0] exp_word(input int i);
    case (i)
      0:  return 32'h1;
      1:  return ej_key[31:0];
      2:  return ej_key[63:32];
      3:  return ej_key[95:64];
      4:  return ej_key[127:96];
      5:  return ej_key[159:128];
      6:  return ej_key[191:160];
      7:  return {19'h0, ej_sar};
      8:  return {19'h0, ej_dar};
      9:  return {19'h0, ej_bsr};
      10: return {30'h0, ej_cmd};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [19:0] addr_of(input int i);
    logic [19:0] a;
    a = BASE + 20'(i);
    return a;
  endfunction

  // Called at +1ns of cycle 0; returns at +1ns of cycle 1 with inputs scrambled.
  task automatic start_job(input logic v, input logic [191:0] k, input logic [12:0] s,
                           input logic [12:0] d, input logic [12:0] b, input logic [1:0] c);
    verify_en = v; key = k; sar = s; dar = d; bsr = b; cmd = c;
    ej_key = k; ej_sar = s; ej_dar = d; ej_bsr = b; ej_cmd = c;
    start = 1'b1;
    cyc = 0;
    #2;
    chk("busy_before_start", busy, 1'b0);
    next_cycle();
    start = 1'b0;
    verify_en = ~v; key = ~k; sar = ~s; dar = ~d; bsr = ~b; cmd = ~c;
  endtask

  task automatic chk_aphase(input string tag, input int i, input logic wr);
    chk({tag, "_hsel"},  bus.AHB_HSEL, 1'b1);
    chk({tag, "_hwrite"}, bus.AHB_HWRITE, wr);
    chk({tag, "_setstr"}, bus.SET_STR, wr);
    chk({tag, "_haddr"}, bus.AHB_HADDR, addr_of(i));
  endtask

  int d0, e0, c0, r0;

  initial begin
    rst = 1'b1; start = 1'b0; verify_en = 1'b0;
    key = '0; sar = '0; dar = '0; bsr = '0; cmd = '0;
    repeat (3) next_cycle();
    rst = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_erraddr", err_addr, 4'h0);
    chk("rst_hsel", bus.AHB_HSEL, 1'b0);
    chk("rst_hwrite", bus.AHB_HWRITE, 1'b0);
    chk("rst_haddr", bus.AHB_HADDR, 20'h0);
    chk("rst_hwdata", bus.AHB_HWDATA, 32'h0);
    next_cycle();

    // ---- write-only job, BASE wraps through 0 ----
    d0 = n_done; e0 = n_errp; c0 = n_ctrl;
    start_job(1'b0, {192{1'b1}}, 13'h1, 13'h10, 13'h100, 2'b01);
    for (int k = 1; k <= 10; k++) begin
      bus.CRYPT_INTR = (k == 3 || k == 4);   // early interrupt must be ignored
      #2;
      chk_aphase("wo_wr", k, 1'b1);
      if (k > 1) chk("wo_hwdata", bus.AHB_HWDATA, exp_word(k - 1));
      chk("wo_busy", busy, 1'b1);
      chk("wo_done_early", done, 1'b0);
      if (k == 7) chk("wo_haddr_top", bus.AHB_HADDR, 20'hFFFFF);
      if (k == 8) chk("wo_haddr_wrap", bus.AHB_HADDR, 20'h00000);
      next_cycle();
    end
    #2;
    chk_aphase("wo_en", 0, 1'b1);
    chk("wo_en_hwdata", bus.AHB_HWDATA, 32'h1);
    next_cycle();
    #2;
    chk("wo_endp_hsel", bus.AHB_HSEL, 1'b0);
    chk("wo_endp_hwdata", bus.AHB_HWDATA, 32'h1);
    chk("wo_endp_haddr", bus.AHB_HADDR, 20'hFFFF8);
    next_cycle();
    while (cyc < 18) begin
      #2;
      chk("wo_wait_done", done, 1'b0);
      chk("wo_wait_hsel", bus.AHB_HSEL, 1'b0);
      next_cycle();
    end
    bus.CRYPT_INTR = 1'b1;
    start = 1'b1;                              // START during DONE is ignored
    #2;
    chk("wo_done", done, 1'b1);
    chk("wo_done_busy", busy, 1'b1);
    next_cycle();
    bus.CRYPT_INTR = 1'b0;
    start = 1'b0;
    #2;
    chk("wo_busy_fall", busy, 1'b0);
    chk("wo_done_fall", done, 1'b0);
    next_cycle();
    #2;
    chk("wo_start_ignored", busy, 1'b0);
    chk("wo_done_cnt", n_done - d0, 1);
    chk("wo_err_cnt", n_errp - e0, 0);
    chk("wo_ctrl_cnt", n_ctrl - c0, 1);
    chk("wo_model_ctrl", model[0], 32'h1);
    chk("wo_model_dar", model[8], 32'h10);
    chk("wo_model_key6", model[6], 32'hFFFFFFFF);
    next_cycle();

    // ---- verify pass ----
    d0 = n_done; e0 = n_errp; c0 = n_ctrl; r0 = n_rd;
    start_job(1'b1, 192'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978,
              13'h1ABC, 13'h0555, 13'h1FFF, 2'b10);
    wait_cyc(11);
    #2;
    chk_aphase("vp_rd1", 1, 1'b0);
    chk("vp_rd1_hwdata", bus.AHB_HWDATA, 32'h2);
    next_cycle();
    while (cyc <= 20) begin
      #2;
      chk_aphase("vp_rd", cyc - 10, 1'b0);
      next_cycle();
    end
    #2;
    chk("vp_rdlast_hsel", bus.AHB_HSEL, 1'b0);
    next_cycle();
    #2;
    chk_aphase("vp_en", 0, 1'b1);
    next_cycle();
    #2;
    chk("vp_endp_hwdata", bus.AHB_HWDATA, 32'h1);
    next_cycle();
    bus.CRYPT_INTR = 1'b1;
    #2;
    chk("vp_done", done, 1'b1);
    next_cycle();
    bus.CRYPT_INTR = 1'b0;
    #2;
    chk("vp_busy_fall", busy, 1'b0);
    chk("vp_rd_cnt", n_rd - r0, 10);
    chk("vp_ctrl_cnt", n_ctrl - c0, 1);
    chk("vp_err_cnt", n_errp - e0, 0);
    chk("vp_done_cnt", n_done - d0, 1);
    chk("vp_model_key1", model[1], 32'h4B5A6978);
    next_cycle();

    // ---- verify fail at index 8 ----
    d0 = n_done; e0 = n_errp; c0 = n_ctrl;
    corrupt_idx = 4'd8;
    start_job(1'b1, 192'hA5A5_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA,
              13'h0AAA, 13'h0555, 13'h0123, 2'b11);
    wait_cyc(19);
    #2;
    chk("vf_err_early", err, 1'b0);
    next_cycle();
    start = 1'b1;                              // START during ERR is ignored
    #2;
    chk("vf_err", err, 1'b1);
    chk("vf_erraddr", err_addr, 4'd8);
    chk("vf_err_busy", busy, 1'b1);
    chk("vf_err_hsel", bus.AHB_HSEL, 1'b0);
    next_cycle();
    start = 1'b0;
    #2;
    chk("vf_busy_fall", busy, 1'b0);
    chk("vf_err_fall", err, 1'b0);
    next_cycle();
    #2;
    chk("vf_start_ignored", busy, 1'b0);
    chk("vf_erraddr_hold", err_addr, 4'd8);
    chk("vf_ctrl_cnt", n_ctrl - c0, 0);
    chk("vf_err_cnt", n_errp - e0, 1);
    chk("vf_done_cnt", n_done - d0, 0);
    corrupt_idx = 4'hF;
    next_cycle();

    // ---- timeout ----
    d0 = n_done; e0 = n_errp;
    start_job(1'b0, {6{32'h13572468}}, 13'h2, 13'h3, 13'h4, 2'b00);
    #2;
    chk("to_erraddr_clr", err_addr, 4'h0);
    next_cycle();
    wait_cyc(28);
    #2;
    chk("to_err_early", err, 1'b0);
    next_cycle();
    #2;
    chk("to_err", err, 1'b1);
    chk("to_erraddr", err_addr, 4'hF);
    next_cycle();
    #2;
    chk("to_busy_fall", busy, 1'b0);
    chk("to_err_cnt", n_errp - e0, 1);
    chk("to_done_cnt", n_done - d0, 0);
    next_cycle();

    // ---- interrupt on the timeout cycle wins ----
    d0 = n_done; e0 = n_errp;
    start_job(1'b0, {6{32'h0BADF00D}}, 13'h5, 13'h6, 13'h7, 2'b01);
    wait_cyc(28);
    bus.CRYPT_INTR = 1'b1;
    #2;
    chk("tie_done", done, 1'b1);
    next_cycle();
    bus.CRYPT_INTR = 1'b0;
    #2;
    chk("tie_no_err", err, 1'b0);
    chk("tie_busy_fall", busy, 1'b0);
    next_cycle();
    chk("tie_err_cnt", n_errp - e0, 0);
    chk("tie_done_cnt", n_done - d0, 1);

    // ---- reset mid-WR at index 4, then restart ----
    d0 = n_done; e0 = n_errp;
    start_job(1'b0, {6{32'hCAFEBABE}}, 13'h8, 13'h9, 13'hA, 2'b10);
    wait_cyc(4);
    rst = 1'b1;
    #2;
    chk_aphase("rs_idx4", 4, 1'b1);
    next_cycle();
    rst = 1'b0;
    #2;
    chk("rs_hsel", bus.AHB_HSEL, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_haddr", bus.AHB_HADDR, 20'h0);
    chk("rs_done", done, 1'b0);
    chk("rs_err", err, 1'b0);
    next_cycle();
    start_job(1'b0, {6{32'hCAFEBABE}}, 13'h8, 13'h9, 13'hA, 2'b10);
    #2;
    chk_aphase("rs_restart", 1, 1'b1);
    next_cycle();
    #2;
    chk("rs_restart_hwdata", bus.AHB_HWDATA, 32'hCAFEBABE);
    next_cycle();
    wait_cyc(13);
    bus.CRYPT_INTR = 1'b1;
    #2;
    chk("rs_done_after", done, 1'b1);
    next_cycle();
    bus.CRYPT_INTR = 1'b0;
    next_cycle();
    chk("rs_done_cnt", n_done - d0, 1);
    chk("rs_err_cnt", n_errp - e0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_cfg_master.md
Name: reg_cfg_master

Overview:
- AHB-side initiator that programs the crypto engine's register block (REG) from a parallel job descriptor, then enables the engine.
- Sequence: config writes, optional readback verify, enable write, wait for CRYPT_INTR.
- Replaces hand-driven bus sequencing and sits between the job controller and REG's AHB slave port.
- Bus is zero-wait-state and pipelined: address phase in cycle n, data phase in cycle n+1. REG has no HREADY.

Parameters:
- BASE_ADDR, 20'h00000, word address of REG register 0; register i is at BASE_ADDR+i.
- TIMEOUT, 16'd1024, AHB_HCLK cycles to wait for CRYPT_INTR before flagging error.

Ports:
- AHB_HCLK  in  1  clock.
- AHB_HRESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle job request; accepted only when BUSY=0.
- VERIFY_EN  in  1  enables the readback phase; sampled with START.
- KEY_IN  in  192  key; sampled with START.
- SAR_IN  in  13  source address; sampled with START.
- DAR_IN  in  13  destination address; sampled with START.
- BSR_IN  in  13  block size; sampled with START.
- CMD_IN  in  2  command; sampled with START.
- BUSY  out  1  job in progress.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR  out  1  one-cycle pulse on verify mismatch or timeout.
- ERR_ADDR  out  4  offending register index; 4'hF = timeout. Held until next START.
- AHB_HSEL  out  1  slave select.
- AHB_HWRITE  out  1  write strobe.
- SET_STR  out  1  store enable to REG; equals AHB_HSEL & AHB_HWRITE.
- AHB_HADDR  out  20  word address.
- AHB_HWDATA  out  32  write data, driven in data phase.
- AHB_HRDATA  in  32  read data, sampled at end of data phase.
- CRYPT_INTR  in  1  engine completion interrupt from REG.

Behaviour:
- Register map (index: content), all zero-extended to 32 bits:
  - 0: CTRL, bit0 = ENABLE.
  - 1..6: KEY[31:0] .. KEY[191:160].
  - 7: SAR. 8: DAR. 9: BSR. 10: CMDR.
- Reset values: all outputs 0, ERR_ADDR 0, state IDLE. Reset mid-job aborts on that edge with no DONE/ERR pulse. AHB_HSEL drops the cycle after reset is sampled.
- Descriptor is latched on START; input changes while BUSY have no effect.
- States and transitions:
  - IDLE: START → WR and BUSY=1; START while BUSY is ignored.
  - WR: address phases for indices 1..10 on consecutive cycles, HSEL=1, HWRITE=1. HWDATA in cycle k carries the word for the index addressed in cycle k-1. After index 10's address phase → RD if VERIFY_EN, else EN.
  - RD:
    - First cycle: data phase of index 10's write overlaps the address phase of index 1 with HWRITE=0, HWDATA still driven.
    - Reads indices 1..10 back-to-back; HRDATA captured each data phase and compared on all 32 bits with the zero-extended expected word.
    - First mismatch → ERRS with ERR_ADDR=index; the data phase already in flight completes but its result is ignored.
    - All equal → EN.
  - EN: one write to index 0 with data 32'h1, followed by its data phase (HSEL=0 during that data cycle unless pipelined) → WAIT.
  - WAIT: HSEL=0. Cycle counter starts at 0 on entry.
    - CRYPT_INTR=1 → DONE pulse, BUSY=0, IDLE.
    - Counter reaching TIMEOUT-1 without interrupt → ERRS with ERR_ADDR=4'hF.
    - Interrupt and timeout in the same cycle: interrupt wins.
    - CRYPT_INTR before WAIT is ignored.
  - ERRS: ERR pulse, BUSY=0, HSEL=0 → IDLE. ENABLE is never written after a verify error.
- Latency from START to the first address phase is 1 cycle.
- Write-only job (VERIFY_EN=0): START edge to EN data phase = 12 cycles.
- START in the same cycle that DONE/ERR is pulsed is ignored (BUSY still 1).
- AHB_HADDR = BASE_ADDR + index, wrapping modulo 2^20. Held stable at the last value when HSEL=0.

Test Plan:
- Write-only job: KEY=192'hFFFF…FFFF, SAR=1, DAR=13'h10, BSR=13'h100, CMD=2'b01, VERIFY_EN=0 → addresses 1..10 then 0 on consecutive cycles, HWDATA one cycle behind. With CRYPT_INTR at +5 cycles, DONE pulses once and BUSY falls.
- Verify pass: bench REG model returns written values → 10 reads observed, then CTRL=1 written, no ERR.
- Verify fail: model corrupts index 8 (returns 32'h11) → ERR pulse, ERR_ADDR=8, no write to index 0, BUSY=0.
- Timeout: TIMEOUT=16, CRYPT_INTR held 0 → ERR exactly 16 cycles after WAIT entry, ERR_ADDR=4'hF. A separate run asserting interrupt and timeout in the same cycle → DONE, not ERR.
- Reset mid-WR at index 4 → next cycle HSEL=0, BUSY=0, no pulses. A new START then restarts from index 1.
- START while BUSY, plus BASE_ADDR=20'hFFFF8 → second START ignored, and addresses wrap from 20'hFFFFF to 20'h00000.
